// File: rtl/spec_tlb_if.sv
// Translation-request / page-table-lookup bundle for spec_tlb.
// slave = TLB side, master = requester plus page-table walker side.
interface spec_tlb_if;
    logic       TRANS_RQST;
    logic [3:0] TRANS_VPN;
    logic       FLUSH;
    logic       TRANS_DONE;
    logic [3:0] TRANS_PFN;
    logic       TRANS_HIT;
    logic       TRANS_FAULT;
    logic       BUSY;
    logic       LOOKUP_RQST;
    logic [3:0] LOOKUP_ADDR;
    logic       LOOKUP_COMPLETE;
    logic [7:0] LOOKUP_RETURN;

    modport slave (
        input  TRANS_RQST, TRANS_VPN, FLUSH, LOOKUP_COMPLETE, LOOKUP_RETURN,
        output TRANS_DONE, TRANS_PFN, TRANS_HIT, TRANS_FAULT, BUSY,
        output LOOKUP_RQST, LOOKUP_ADDR
    );

    modport master (
        output TRANS_RQST, TRANS_VPN, FLUSH, LOOKUP_COMPLETE, LOOKUP_RETURN,
        input  TRANS_DONE, TRANS_PFN, TRANS_HIT, TRANS_FAULT, BUSY,
        input  LOOKUP_RQST, LOOKUP_ADDR
    );
endinterface

// File: rtl/spec_tlb.sv
// Small fully-associative TLB with a single outstanding page-table walk.
// IDLE accepts a request and compares all tags at once; a hit answers in
// RESP on the next cycle, a miss issues a walk (WALK) that ends in a fill,
// a tag-mismatch fault or a timeout fault. Every output is a flop.
module spec_tlb #(
    parameter int TLB_ENTRIES    = 4,
    parameter int LOOKUP_TIMEOUT = 16
) (
    input  logic      clk,
    input  logic      rst_n,
    spec_tlb_if.slave bus
);

    localparam int IDX_W = (TLB_ENTRIES > 1) ? $clog2(TLB_ENTRIES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TLB_ENTRIES - 1);
    localparam logic [7:0]       TMO_LIM  = 8'(LOOKUP_TIMEOUT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WALK = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Registered outputs and their next values.
    logic       done_q,  done_d;
    logic [3:0] pfn_q,   pfn_d;
    logic       hit_q,   hit_d;
    logic       fault_q, fault_d;
    logic       busy_q,  busy_d;
    logic       rqst_q,  rqst_d;
    // LOOKUP_ADDR doubles as the latched VPN while a walk is in flight.
    logic [3:0] addr_q,  addr_d;
    logic [7:0] tmo_q,   tmo_d;

    // Translation table.
    logic [TLB_ENTRIES-1:0] valid_q;
    logic [3:0]             tag_q   [TLB_ENTRIES];
    logic [3:0]             frame_q [TLB_ENTRIES];
    logic [IDX_W-1:0]       ptr_q;

    logic             lkp_hit;
    logic [3:0]       lkp_pfn;
    logic [IDX_W-1:0] victim;
    logic             all_valid;
    logic             fill_en;
    logic             fill_do;

    assign bus.TRANS_DONE  = done_q;
    assign bus.TRANS_PFN   = pfn_q;
    assign bus.TRANS_HIT   = hit_q;
    assign bus.TRANS_FAULT = fault_q;
    assign bus.BUSY        = busy_q;
    assign bus.LOOKUP_RQST = rqst_q;
    assign bus.LOOKUP_ADDR = addr_q;

    // Parallel tag compare of the incoming VPN; tags are unique so at most one hits.
    always_comb begin
        // NOTE: every variable written here gets a default first so no latch is inferred.
        lkp_hit = 1'b0;
        lkp_pfn = 4'd0;
        for (int i = 0; i < TLB_ENTRIES; i++) begin
            if (valid_q[i] && (tag_q[i] == bus.TRANS_VPN)) begin
                lkp_hit = 1'b1;
                lkp_pfn = frame_q[i];
            end
        end
    end

    // Victim choice: lowest invalid slot, else the round-robin slot.
    always_comb begin
        victim    = ptr_q;
        all_valid = &valid_q;
        for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                victim = IDX_W'(i);
            end
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        pfn_d   = pfn_q;
        hit_d   = hit_q;
        fault_d = fault_q;
        busy_d  = busy_q;
        rqst_d  = rqst_q;
        addr_d  = addr_q;
        tmo_d   = tmo_q;
        fill_en = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.TRANS_RQST) begin
                    busy_d = 1'b1;
                    if (lkp_hit) begin
                        state_d = RESP;
                        done_d  = 1'b1;
                        pfn_d   = lkp_pfn;
                        hit_d   = 1'b1;
                        fault_d = 1'b0;
                    end else begin
                        state_d = WALK;
                        rqst_d  = 1'b1;
                        addr_d  = bus.TRANS_VPN;
                        tmo_d   = 8'd0;
                    end
                end
            end

            WALK: begin
                // LOOKUP_RETURN is only looked at when LOOKUP_COMPLETE is high.
                if (bus.LOOKUP_COMPLETE) begin
                    state_d = RESP;
                    done_d  = 1'b1;
                    rqst_d  = 1'b0;
                    hit_d   = 1'b0;
                    if (bus.LOOKUP_RETURN[7:4] == addr_q) begin
                        pfn_d   = bus.LOOKUP_RETURN[3:0];
                        fault_d = 1'b0;
                        fill_en = 1'b1;
                    end else begin
                        pfn_d   = 4'd0;
                        fault_d = 1'b1;
                    end
                end else begin
                    tmo_d = tmo_q + 8'd1;
                    // Request rose at the accepting edge, so it stays high for
                    // exactly LOOKUP_TIMEOUT cycles before falling here.
                    if (tmo_d == TMO_LIM) begin
                        state_d = RESP;
                        done_d  = 1'b1;
                        rqst_d  = 1'b0;
                        hit_d   = 1'b0;
                        pfn_d   = 4'd0;
                        fault_d = 1'b1;
                    end
                end
            end

            RESP: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                rqst_d  = 1'b0;
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                rqst_d  = 1'b0;
            end
        endcase
    end

    // A flush on the fill edge wins: the walk result is reported but not stored.
    assign fill_do = fill_en && !bus.FLUSH;

    // State and registered-output flops.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!rst_n) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
            pfn_q   <= 4'd0;
            hit_q   <= 1'b0;
            fault_q <= 1'b0;
            busy_q  <= 1'b0;
            rqst_q  <= 1'b0;
            addr_q  <= 4'd0;
            tmo_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            pfn_q   <= pfn_d;
            hit_q   <= hit_d;
            fault_q <= fault_d;
            busy_q  <= busy_d;
            rqst_q  <= rqst_d;
            addr_q  <= addr_d;
            tmo_q   <= tmo_d;
        end
    end

    // Valid bits and replacement pointer; flush clears both from any state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            ptr_q   <= '0;
        end else if (bus.FLUSH) begin
            valid_q <= '0;
            ptr_q   <= '0;
        end else if (fill_do) begin
            valid_q[victim] <= 1'b1;
            if (all_valid) begin
                ptr_q <= (ptr_q == LAST_IDX) ? '0 : ptr_q + 1'b1;
            end
        end
    end

    // Tag/frame storage written on a fill.
    always_ff @(posedge clk) begin
        // NOTE: storage has no reset; the valid bits alone decide whether an entry means anything.
        if (fill_do) begin
            tag_q[victim]   <= addr_q;
            frame_q[victim] <= bus.LOOKUP_RETURN[3:0];
        end
    end

endmodule

// File: tb/tb_spec_tlb.sv
// Directed bench for spec_tlb: stimulus pushes the expected response into a
// scoreboard queue, a negedge monitor pops and compares on every TRANS_DONE.
module tb_spec_tlb;

    localparam int TLB_ENTRIES    = 4;
    localparam int LOOKUP_TIMEOUT = 16;
    localparam int NO_COMPLETE    = 99;

    logic clk = 1'b0;
    logic rst_n;

    spec_tlb_if bus ();

    spec_tlb #(
        .TLB_ENTRIES   (TLB_ENTRIES),
        .LOOKUP_TIMEOUT(LOOKUP_TIMEOUT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] pfn;
        logic       hit;
        logic       fault;
        string      name;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every completion pulse must match the oldest expected response.
    always @(negedge clk) begin
        if (bus.TRANS_DONE === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got pfn=%0h hit=%0b fault=%0b with nothing expected",
                         bus.TRANS_PFN, bus.TRANS_HIT, bus.TRANS_FAULT);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, "_resp{pfn,hit,fault}"},
                      {bus.TRANS_PFN, bus.TRANS_HIT, bus.TRANS_FAULT},
                      {e.pfn, e.hit, e.fault});
            end
        end
    end

    // One translation. delay = cycles in WALK before LOOKUP_COMPLETE,
    // NO_COMPLETE lets the walk time out.
    task automatic txn(input string name, input logic [3:0] vpn, input logic [7:0] ret,
                       input int delay, input bit flush_acc, input bit flush_fill,
                       input logic [3:0] e_pfn, input bit e_hit, input bit e_fault);
        exp_t e;
        int   n;
        int   bad;
        e.pfn   = e_pfn;
        e.hit   = e_hit;
        e.fault = e_fault;
        e.name  = name;
        sb.push_back(e);

        @(negedge clk);
        bus.TRANS_RQST = 1'b1;
        bus.TRANS_VPN  = vpn;
        bus.FLUSH      = flush_acc;
        @(negedge clk);
        bus.TRANS_RQST = 1'b0;
        bus.TRANS_VPN  = 4'hF;
        bus.FLUSH      = 1'b0;

        if (e_hit) begin
            check({name, "_done_lat1"}, bus.TRANS_DONE, 1);
            check({name, "_no_lookup"}, bus.LOOKUP_RQST, 0);
        end else begin
            check({name, "_lookup{rqst,addr}"}, {bus.LOOKUP_RQST, bus.LOOKUP_ADDR}, {1'b1, vpn});
            if (delay >= LOOKUP_TIMEOUT) begin
                n   = 0;
                bad = 0;
                while (bus.LOOKUP_RQST && n < 100) begin
                    n++;
                    if (bus.LOOKUP_ADDR !== vpn) bad++;
                    @(negedge clk);
                end
                check({name, "_rqst_cycles"}, n, LOOKUP_TIMEOUT);
                check({name, "_addr_unstable_cycles"}, bad, 0);
            end else begin
                repeat (delay) @(negedge clk);
                bus.LOOKUP_COMPLETE = 1'b1;
                bus.LOOKUP_RETURN   = ret;
                bus.FLUSH           = flush_fill;
                @(negedge clk);
                bus.LOOKUP_COMPLETE = 1'b0;
                bus.LOOKUP_RETURN   = 8'h00;
                bus.FLUSH           = 1'b0;
            end
        end

        n = 0;
        while ((bus.BUSY || bus.TRANS_DONE) && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL %s_idle_wait: got busy after %0d cycles expected idle", name, n);
        end
    endtask

    task automatic flush_pulse();
        @(negedge clk);
        bus.FLUSH = 1'b1;
        @(negedge clk);
        bus.FLUSH = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n               = 1'b0;
        bus.TRANS_RQST      = 1'b0;
        bus.TRANS_VPN       = 4'h0;
        bus.FLUSH           = 1'b0;
        bus.LOOKUP_COMPLETE = 1'b0;
        bus.LOOKUP_RETURN   = 8'h00;
        #1;
        check("reset_outputs",
              {bus.TRANS_DONE, bus.TRANS_PFN, bus.TRANS_HIT, bus.TRANS_FAULT,
               bus.BUSY, bus.LOOKUP_RQST, bus.LOOKUP_ADDR}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Tag mismatch: fault, no fill (the following request still misses).
        txn("mismatch3",  4'h3, 8'h7C, 1, 0, 0, 4'h0, 0, 1);
        // Cold miss then hit.
        txn("cold_miss3", 4'h3, 8'h3A, 2, 0, 0, 4'hA, 0, 0);
        txn("hit3",       4'h3, 8'h00, 0, 0, 0, 4'hA, 1, 0);

        // Flush between fill and reuse, then flush on the fill edge.
        flush_pulse();
        txn("postflush_miss3", 4'h3, 8'h3A, 0, 0, 0, 4'hA, 0, 0);
        flush_pulse();
        txn("fillflush3",      4'h3, 8'h3A, 1, 0, 1, 4'hA, 0, 0);
        txn("after_ff_miss3",  4'h3, 8'h3A, 0, 0, 0, 4'hA, 0, 0);

        // Timeout, then a retry of the same VPN walks again.
        txn("timeout9",   4'h9, 8'h00, NO_COMPLETE, 0, 0, 4'h0, 0, 1);
        txn("retry9",     4'h9, 8'h95, 3, 0, 0, 4'h5, 0, 0);

        // Replacement on a clean table of 4 entries.
        flush_pulse();
        txn("fill1", 4'h1, 8'h1B, 0, 0, 0, 4'hB, 0, 0);
        txn("fill2", 4'h2, 8'h2C, 0, 0, 0, 4'hC, 0, 0);
        txn("fill3", 4'h3, 8'h3D, 0, 0, 0, 4'hD, 0, 0);
        txn("fill4", 4'h4, 8'h4E, 0, 0, 0, 4'hE, 0, 0);
        txn("evict_slot0_5", 4'h5, 8'h56, 0, 0, 0, 4'h6, 0, 0);
        txn("hit2",          4'h2, 8'h00, 0, 0, 0, 4'hC, 1, 0);
        txn("miss1",         4'h1, 8'h1B, 0, 0, 0, 4'hB, 0, 0);
        txn("hit5",          4'h5, 8'h00, 0, 0, 0, 4'h6, 1, 0);
        txn("miss2",         4'h2, 8'h2C, 0, 0, 0, 4'hC, 0, 0);
        txn("hit4",          4'h4, 8'h00, 0, 0, 0, 4'hE, 1, 0);
        txn("hit1",          4'h1, 8'h00, 0, 0, 0, 4'hB, 1, 0);

        // Hit coinciding with flush uses pre-flush contents; table empty afterwards.
        txn("hit4_flush",    4'h4, 8'h00, 0, 1, 0, 4'hE, 1, 0);
        txn("miss4",         4'h4, 8'h4E, 0, 0, 0, 4'hE, 0, 0);

        // Reset in the middle of a walk.
        @(negedge clk);
        bus.TRANS_RQST = 1'b1;
        bus.TRANS_VPN  = 4'h8;
        @(negedge clk);
        bus.TRANS_RQST = 1'b0;
        check("rmw_walking", bus.LOOKUP_RQST, 1);
        #2 rst_n = 1'b0;
        #1 check("rmw_async_drop{rqst,busy,done}",
                 {bus.LOOKUP_RQST, bus.BUSY, bus.TRANS_DONE}, 0);
        bus.LOOKUP_COMPLETE = 1'b1;
        bus.LOOKUP_RETURN   = 8'h8F;
        repeat (2) @(negedge clk);
        bus.LOOKUP_COMPLETE = 1'b0;
        bus.LOOKUP_RETURN   = 8'h00;
        rst_n               = 1'b1;
        repeat (3) @(negedge clk);
        check("rmw_idle_after", bus.BUSY, 0);
        txn("rmw_miss4", 4'h4, 8'h4E, 1, 0, 0, 4'hE, 0, 0);
        txn("rmw_miss8", 4'h8, 8'h8F, 0, 0, 0, 4'hF, 0, 0);

        repeat (2) @(negedge clk);
        check("scoreboard_left", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spec_tlb.md
SPEC_TLB -- requirements
Module: spec_tlb

Interface
REQ-001 SHALL have parameter TLB_ENTRIES, default 4: number of fully-associative entries, legal range 2..8.
REQ-002 SHALL have parameter LOOKUP_TIMEOUT, default 16: maximum number of WALK cycles before a fault, legal range 1..255.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port TRANS_RQST, input, 1 bit: translation request; sampled only in IDLE.
REQ-006 SHALL have port TRANS_VPN, input, 4 bits: virtual page number; sampled with TRANS_RQST.
REQ-007 SHALL have port FLUSH, input, 1 bit: invalidates all entries.
REQ-008 SHALL have port TRANS_DONE, output, 1 bit: one-cycle completion pulse.
REQ-009 SHALL have port TRANS_PFN, output, 4 bits: physical frame number; valid while TRANS_DONE=1.
REQ-010 SHALL have port TRANS_HIT, output, 1 bit: 1 = served from TLB, 0 = served by a walk; valid while TRANS_DONE=1.
REQ-011 SHALL have port TRANS_FAULT, output, 1 bit: translation failed; valid while TRANS_DONE=1.
REQ-012 SHALL have port BUSY, output, 1 bit: 1 in every state except IDLE.
REQ-013 SHALL have port LOOKUP_RQST, output, 1 bit: page-table lookup request.
REQ-014 SHALL have port LOOKUP_ADDR, output, 4 bits: VPN being looked up.
REQ-015 SHALL have port LOOKUP_COMPLETE, input, 1 bit: page-table lookup done.
REQ-016 SHALL have port LOOKUP_RETURN, input, 8 bits: page-table entry, [7:4]=VPN, [3:0]=PFN; may be Z when LOOKUP_COMPLETE=0 and SHALL be ignored then.

Function
REQ-017 SHALL implement states IDLE, WALK and RESP; all outputs SHALL be registered.
REQ-018 SHALL, in IDLE, accept TRANS_RQST=1 at a rising edge, latch TRANS_VPN and compare it against all valid tags in parallel.
REQ-019 SHALL, on a hit, go to RESP with PFN = entry PFN, HIT=1, FAULT=0; TRANS_DONE is high in the cycle after the accepting edge, giving a hit latency of 1.
REQ-020 SHALL, on a miss, go to WALK, set LOOKUP_RQST=1, set LOOKUP_ADDR=latched VPN, and clear the timeout counter.
REQ-021 SHALL, in WALK, hold LOOKUP_RQST and LOOKUP_ADDR stable until leaving WALK.
REQ-022 SHALL, in WALK at an edge with LOOKUP_COMPLETE=1 and LOOKUP_RETURN[7:4]=VPN, write {VPN, PFN} into an entry, set it valid, and go to RESP with HIT=0, FAULT=0, PFN=LOOKUP_RETURN[3:0].
REQ-023 SHALL, in WALK at an edge with LOOKUP_COMPLETE=1 and a tag mismatch, go to RESP with FAULT=1, PFN=0, and no fill.
REQ-024 SHALL, in WALK at an edge with LOOKUP_COMPLETE=0, increment the timeout counter.
REQ-025 SHALL, when the timeout counter reaches LOOKUP_TIMEOUT, go to RESP with FAULT=1 and no fill, so that LOOKUP_RQST is high for exactly LOOKUP_TIMEOUT cycles.
REQ-026 SHALL, in RESP, assert TRANS_DONE for exactly one cycle, force LOOKUP_RQST=0, and return to IDLE; consecutive walks are therefore separated by at least 2 cycles with LOOKUP_RQST low.
REQ-027 SHALL ignore TRANS_RQST and TRANS_VPN while BUSY=1; no queuing.
REQ-028 SHALL choose the fill victim as the lowest-index invalid entry; if all entries are valid, the entry at the round-robin pointer.
REQ-029 SHALL advance the round-robin pointer by 1 only on fills that evict, wrapping from TLB_ENTRIES-1 to 0.
REQ-030 SHALL NOT create duplicate tags; a fill occurs only after a miss.
REQ-031 SHALL, on FLUSH=1 at an edge in any state, clear all valid bits and the pointer.
REQ-032 SHALL, when FLUSH coincides with a fill edge, let FLUSH win: no entry is written, and the response is still delivered with HIT=0.
REQ-033 SHALL, on a hit lookup coinciding with FLUSH in IDLE, use the pre-flush contents for the response.

Reset
REQ-034 SHALL, on rst_n=0, immediately set state=IDLE and TRANS_DONE, TRANS_PFN, TRANS_HIT, TRANS_FAULT, BUSY, LOOKUP_RQST and LOOKUP_ADDR all to 0, and clear all valid bits, the pointer and the timeout counter.
REQ-035 SHALL, on reset during WALK, drop LOOKUP_RQST asynchronously; the abandoned walk produces no TRANS_DONE and no fill.

Verification
REQ-036 Cold miss then hit: page table holds 8'h3A; request VPN 3 -> LOOKUP_RQST=1, LOOKUP_ADDR=3, then TRANS_DONE pulse with PFN=A, HIT=0; repeat VPN 3 -> TRANS_DONE 1 cycle after acceptance with HIT=1 and no LOOKUP_RQST.
REQ-037 Replacement: TLB_ENTRIES=4, misses on VPN 1,2,3,4, then 5 -> VPN 5 evicts slot 0; request VPN 1 misses, VPN 2 hits.
REQ-038 Timeout: LOOKUP_COMPLETE held 0 -> LOOKUP_RQST high exactly 16 cycles, then TRANS_DONE with FAULT=1; repeat request misses again.
REQ-039 Tag mismatch: request VPN 3 answered with LOOKUP_RETURN=8'h7C -> FAULT=1, PFN=0, entry not filled.
REQ-040 FLUSH: after filling VPN 3, pulse FLUSH -> VPN 3 misses; FLUSH on the fill edge -> TRANS_DONE with HIT=0, then next VPN 3 request misses.
REQ-041 Reset mid-walk: drive rst_n=0 during WALK -> LOOKUP_RQST=0 without a clock edge, BUSY=0, no TRANS_DONE; VPN previously cached misses after reset.
